// File: rtl/ch_rr_arbiter.sv
// -----------------------------------------------------------------------------
// ch_rr_arbiter
//
// Round-robin channel arbiter. It sits between the read-side channel
// configuration FSM and the per-channel transfer engine. Newly activated
// channels are collected in a pending mask and handed to the engine one at a
// time. Each finished channel is reported with a one-cycle ch_done/ch_id pair.
//
// Optional feature: define ARB_TIMEOUT_EN to add an engine watchdog. A channel
// that stays in BUSY for TIMEOUT_CYCLES cycles is forced to complete with
// ch_err=1. Without the macro, ch_err is tied to 0 and BUSY waits forever.
//
// Ports:
//   AXI_aclk          rising-edge clock
//   AXI_areset        asynchronous, active-high reset
//   ActiveChannels    newly activated channel mask (qualified by validChannels)
//   validChannels     single-cycle qualifier for ActiveChannels
//   CPU_interrupt_end flushes the pending mask
//   eng_req           grant offered to the engine
//   eng_ch_id         channel being granted, stable while eng_req is high
//   eng_ack           engine accepts the grant
//   eng_done          engine finished the granted channel (used only in BUSY)
//   ch_id             id of the completed channel
//   ch_done           one-cycle completion pulse
//   ch_err            completion was caused by a timeout (qualified by ch_done)
//   pending           current pending mask
// -----------------------------------------------------------------------------
module ch_rr_arbiter #(
   parameter int NUM_CH         = 32,
   parameter int CH_ID_WIDTH    = 6,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   AXI_aclk,
   input  logic                   AXI_areset,
   input  logic [NUM_CH-1:0]      ActiveChannels,
   input  logic                   validChannels,
   input  logic                   CPU_interrupt_end,
   output logic                   eng_req,
   output logic [CH_ID_WIDTH-1:0] eng_ch_id,
   input  logic                   eng_ack,
   input  logic                   eng_done,
   output logic [CH_ID_WIDTH-1:0] ch_id,
   output logic                   ch_done,
   output logic                   ch_err,
   output logic [NUM_CH-1:0]      pending
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_BUSY = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Reject parameter sets the id buses or the watchdog cannot represent.
   if (NUM_CH > (2 ** CH_ID_WIDTH) || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("ch_rr_arbiter: NUM_CH must fit in CH_ID_WIDTH and TIMEOUT_CYCLES must be >= 2");
   end

   logic [1:0]             state;
   logic [CH_ID_WIDTH-1:0] last;
   logic [CH_ID_WIDTH-1:0] winner;
   logic [NUM_CH-1:0]      pending_nxt;
   logic                   accept;

   assign accept = (state == ST_REQ) && eng_ack;

   // Round-robin pick: the lowest set bit above 'last' wins; if there is none,
   // the lowest set bit at or below 'last' wins (the wrap-around). Both scans
   // run from high to low, so the last match of each scan is the lowest
   // matching bit. The second scan runs later, so a match above 'last' beats
   // any wrapped match.
   // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      winner = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (pending[k] && (CH_ID_WIDTH'(k) <= last)) winner = CH_ID_WIDTH'(k);
      end
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (pending[k] && (CH_ID_WIDTH'(k) > last)) winner = CH_ID_WIDTH'(k);
      end
   end

   // Pending-mask priorities, lowest first: clear on acceptance, then set
   // (a reload in the same cycle re-queues the channel), then flush.
   always_comb begin
      pending_nxt = pending;
      if (accept) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (eng_ch_id == CH_ID_WIDTH'(k)) pending_nxt[k] = 1'b0;
         end
      end
      if (validChannels)     pending_nxt = pending_nxt | ActiveChannels;
      if (CPU_interrupt_end) pending_nxt = '0;
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] busy_cnt;
   logic             err_q;

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
      if (AXI_areset) begin
         state     <= ST_IDLE;
         last      <= CH_ID_WIDTH'(NUM_CH - 1);
         pending   <= '0;
         eng_ch_id <= '0;
         ch_id     <= '0;
         busy_cnt  <= '0;
         err_q     <= 1'b0;
      end else begin
         pending <= pending_nxt;
         case (state)
            ST_IDLE: begin
               if ((pending != '0) && !CPU_interrupt_end) begin
                  eng_ch_id <= winner;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (eng_ack) begin
                  last     <= eng_ch_id;
                  busy_cnt <= '0;
                  state    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // A real completion in the last watchdog cycle wins over the timeout.
               if (eng_done) begin
                  ch_id <= eng_ch_id;
                  err_q <= 1'b0;
                  state <= ST_DONE;
               end else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  ch_id <= eng_ch_id;
                  err_q <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  busy_cnt <= busy_cnt + 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ch_err = (state == ST_DONE) && err_q;
`else
   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge AXI_aclk or posedge AXI_areset) begin
      if (AXI_areset) begin
         state     <= ST_IDLE;
         last      <= CH_ID_WIDTH'(NUM_CH - 1);
         pending   <= '0;
         eng_ch_id <= '0;
         ch_id     <= '0;
      end else begin
         pending <= pending_nxt;
         case (state)
            ST_IDLE: begin
               if ((pending != '0) && !CPU_interrupt_end) begin
                  eng_ch_id <= winner;
                  state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (eng_ack) begin
                  last  <= eng_ch_id;
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (eng_done) begin
                  ch_id <= eng_ch_id;
                  state <= ST_DONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign ch_err = 1'b0;
`endif

   // Handshake outputs decode straight from the state register, so no input
   // reaches an output combinationally.
   assign eng_req = (state == ST_REQ);
   assign ch_done = (state == ST_DONE);

endmodule

// File: doc/ch_rr_arbiter.md
# ch_rr_arbiter

Round-robin channel arbiter between the read-side channel configuration FSM and the per-channel transfer engine. It accumulates newly activated channels into a pending mask and grants them one at a time to the engine. When the engine finishes a channel, the arbiter reports it with a one-cycle `ch_done`/`ch_id` pair. The write-side configuration FSM consumes that pair to clear the channel's active bit and raise the CPU interrupt.

## Interface
Parameters:
- `NUM_CH`, 32: number of DMA channels; `NUM_CH <= 2**CH_ID_WIDTH`.
- `CH_ID_WIDTH`, 6: width of all channel-id buses.
- `TIMEOUT_CYCLES`, 1024: engine watchdog limit. Used only with `ARB_TIMEOUT_EN`.

Ports:
- `AXI_aclk` in 1: the single clock; all logic is on its rising edge.
- `AXI_areset` in 1: asynchronous, active-high reset.
- `ActiveChannels` in `NUM_CH`: newly activated channel mask.
- `validChannels` in 1: single-cycle qualifier for `ActiveChannels`.
- `CPU_interrupt_end` in 1: flush the pending mask.
- `eng_req` out 1: a grant is offered to the engine.
- `eng_ch_id` out `CH_ID_WIDTH`: the channel being granted.
- `eng_ack` in 1: the engine accepts the grant.
- `eng_done` in 1: the engine has finished the granted channel.
- `ch_id` out `CH_ID_WIDTH`: id of the completed channel.
- `ch_done` out 1: single-cycle completion pulse.
- `ch_err` out 1: the completion was caused by a timeout; qualified by `ch_done`.
- `pending` out `NUM_CH`: current pending mask (status).

## Operation
- Pending mask `P`:
  - On `validChannels`: `P <= P | ActiveChannels`.
  - On grant acceptance (REQ state and `eng_ack`): bit `eng_ch_id` is cleared.
  - Set and clear in the same cycle: set wins, so the channel is re-queued.
  - `CPU_interrupt_end` clears `P` to 0 and has priority over both set and clear. A channel already in flight completes normally.
- Round-robin pointer `last`:
  - Reset value is `NUM_CH-1`, so channel 0 wins first after reset.
  - The winner is the first set bit of `P` scanning `last+1`, `last+2`, … with wrap modulo `NUM_CH`.
  - `last` updates to the winner at acceptance.
- FSM states: IDLE, REQ, BUSY, DONE.
  - IDLE: if `P != 0` and `CPU_interrupt_end` is low, latch the winner into `eng_ch_id` and go to REQ. Otherwise stay in IDLE.
  - REQ: `eng_req = 1`. `eng_ch_id` holds stable until `eng_ack`. On `eng_ack` go to BUSY.
  - BUSY: on `eng_done`, latch `ch_id <= eng_ch_id` and go to DONE. Any `eng_done` outside BUSY is ignored.
  - DONE: `ch_done = 1` for exactly one cycle, then go to IDLE.
- The engine never sees a second request while a channel is in flight; there is at most one outstanding grant.
- Reset values:
  - outputs: `eng_req=0`, `eng_ch_id=0`, `ch_id=0`, `ch_done=0`, `ch_err=0`, `pending=0`
  - internal: state IDLE, `last=NUM_CH-1`
- Reset asserted mid-transfer returns the block to IDLE immediately. The in-flight channel is dropped without a `ch_done`.

## Timing
- `eng_req`, `ch_done` and `ch_err` decode directly from the state register. There is no combinational path from any input to any output.
- `validChannels` in cycle t: `P` is updated at t+1, and `eng_req` is high at t+2 (when the block is IDLE).
- `eng_ack` sampled high in cycle t: `eng_req` is low at t+1.
- `eng_done` sampled high in BUSY at cycle t: `ch_done` is high in cycle t+1 only.
- Back-to-back grants: after DONE there is one IDLE cycle, then the next REQ. Steady-state overhead is 3 cycles plus engine latency per channel.
- `eng_ack` and `eng_done` high in the same cycle while in REQ: only `eng_ack` is honoured. `eng_done` must follow in BUSY.

## Configuration
- Macro `ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to BUSY and increments each cycle in BUSY.
  - If it reaches `TIMEOUT_CYCLES-1` without `eng_done`, go to DONE with `ch_err=1`. `ch_id` is the stuck channel and `ch_done` pulses as normal.
  - `eng_done` arriving in that same cycle takes precedence, giving `ch_err=0`.
- Undefined: no counter exists; `ch_err` is tied to 0 and BUSY waits indefinitely.

## Test plan
- **Reset:** assert `AXI_areset` while in BUSY → all outputs 0 next edge; `pending=0`; no `ch_done`.
- **Round-robin with wrap:** `ActiveChannels=32'h8000_0005` with `validChannels` pulse; engine acks and completes each grant after 2 cycles → `ch_done` order is ids 0, 2, 31. Each pulse is one cycle; `pending` then reads 0.
- **Set/clear collision:** reload bit 2 with `validChannels` in the same cycle that `eng_ack` accepts channel 2 → `pending[2]` stays 1, and channel 2 is granted again after the other pending channels.
- **Flush:** `pending=32'h0000_00F0` with channel 4 in BUSY, pulse `CPU_interrupt_end` → `pending=0`. Channel 4 still reports `ch_done` with `ch_id=4`; there are no further `eng_req`.
- **Handshake hold:** hold `eng_ack` low for 10 cycles → `eng_req` and `eng_ch_id` stay stable. A spurious `eng_done` during REQ produces no `ch_done`.
- **Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=16`):** grant channel 7 and never assert `eng_done` → `ch_done=1`, `ch_err=1`, `ch_id=7` exactly 16 cycles after BUSY entry.
